// File: rtl/ray_pkg.sv
// Shared types and constants for the ray/block intersection initiator.
// Float fields are handled as raw IEEE-754 single bit patterns only.
package ray_pkg;

  typedef logic [31:0] float32_t;

  localparam float32_t   FLOAT_POS_INF      = 32'h7F80_0000;
  localparam logic [7:0] FLOAT_EXP_ALL_ONES = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  // Usable hit: flagged, sign clear, and neither NaN nor infinity.
  function automatic logic is_candidate(input logic hit, input float32_t t);
    return hit && !t[31] && (t[30:23] != FLOAT_EXP_ALL_ONES);
  endfunction

endpackage

// File: rtl/nearest_hit_reducer.sv
// Keeps the nearest non-negative, finite hit seen so far within one scan.
// Outputs are the look-ahead record so the caller can capture it on the same edge as the last result.
module nearest_hit_reducer
  import ray_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic             hit_i,
  input  float32_t         t_i,
  input  logic [IDX_W-1:0] index_i,
  output logic             best_valid_o,
  output logic [IDX_W-1:0] best_index_o,
  output float32_t         best_t_o
);

  logic             best_valid_q, best_valid_d;
  logic [IDX_W-1:0] best_index_q, best_index_d;
  float32_t         best_t_q, best_t_d;
  logic             take;

  // Both operands are non-negative, so magnitude bits order like the floats; strict < keeps the lower index on ties.
  assign take = valid_i && is_candidate(hit_i, t_i) &&
                (!best_valid_q || (t_i[30:0] < best_t_q[30:0]));

  always_comb begin
    best_valid_d = best_valid_q;
    best_index_d = best_index_q;
    best_t_d     = best_t_q;
    if (clear_i) begin
      best_valid_d = 1'b0;
      best_index_d = '0;
      best_t_d     = FLOAT_POS_INF;
    end else if (take) begin
      best_valid_d = 1'b1;
      best_index_d = index_i;
      best_t_d     = t_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      best_valid_q <= 1'b0;
      best_index_q <= '0;
      best_t_q     <= FLOAT_POS_INF;
    end else begin
      best_valid_q <= best_valid_d;
      best_index_q <= best_index_d;
      best_t_q     <= best_t_d;
    end
  end

  assign best_valid_o = best_valid_d;
  assign best_index_o = best_index_d;
  assign best_t_o     = best_t_d;

endmodule

// File: rtl/ray_nearest_block_scan.sv
// Scans all blocks against one ray through the intersection unit and reports the nearest hit.
// state    | meaning
// ST_IDLE  | waiting for start_in; results hold
// ST_ISSUE | presenting block addresses 0..NUM_BLOCKS-1, one per cycle
// ST_DRAIN | waiting for the remaining in-order intersection results
// ST_DONE  | one-cycle done_out pulse, results valid
module ray_nearest_block_scan
  import ray_pkg::*;
#(
  parameter int NUM_BLOCKS = 64,
  parameter int ADDR_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [31:0]       ray_x_in,
  input  logic [31:0]       ray_y_in,
  input  logic [31:0]       ray_z_in,
  output logic              busy_out,
  output logic [ADDR_W-1:0] block_addr_out,
  input  logic [31:0]       block_pos_x_in,
  input  logic [31:0]       block_pos_y_in,
  input  logic [31:0]       block_pos_z_in,
  output logic [31:0]       isect_ray_x_out,
  output logic [31:0]       isect_ray_y_out,
  output logic [31:0]       isect_ray_z_out,
  output logic [31:0]       isect_block_x_out,
  output logic [31:0]       isect_block_y_out,
  output logic [31:0]       isect_block_z_out,
  output logic              isect_valid_out,
  input  logic              isect_hit_in,
  input  logic [31:0]       isect_t_in,
  input  logic              isect_valid_in,
  output logic              hit_out,
  output logic [ADDR_W-1:0] hit_index_out,
  output logic [31:0]       hit_t_out,
  output logic              done_out
);

  localparam int                CNT_W     = $clog2(NUM_BLOCKS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLOCKS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_BLOCKS - 1);
  localparam logic [CNT_W-1:0]  CNT_ALL   = CNT_W'(NUM_BLOCKS);

  scan_state_e       state_q, state_d;
  logic              start_scan;
  logic              accept;
  logic              enter_done;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic              issue_d1_q;

  float32_t          ray_x_q, ray_y_q, ray_z_q;
  float32_t          qblk_x_q, qblk_y_q, qblk_z_q;
  logic              qvalid_q;

  logic              hit_q;
  logic [ADDR_W-1:0] hit_index_q;
  float32_t          hit_t_q;

  logic              rec_valid;
  logic [ADDR_W-1:0] rec_index;
  float32_t          rec_t;

  assign accept = isect_valid_in && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

  always_comb begin
    state_d    = state_q;
    start_scan = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d    = ST_ISSUE;
          start_scan = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Go on the edge that accepts the final result so done lands the very next cycle.
        if ((ret_cnt_q == CNT_ALL) || (accept && (ret_cnt_q == CNT_LAST))) begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (start_scan)                                  addr_d = '0;
    else if ((state_q == ST_ISSUE) && (addr_q != LAST_ADDR)) addr_d = addr_q + ADDR_W'(1);
  end

  always_comb begin
    ret_cnt_d = ret_cnt_q;
    if (start_scan)  ret_cnt_d = '0;
    else if (accept) ret_cnt_d = ret_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      ret_cnt_q  <= '0;
      issue_d1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ret_cnt_q  <= ret_cnt_d;
      issue_d1_q <= (state_q == ST_ISSUE);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ray_x_q <= '0;
      ray_y_q <= '0;
      ray_z_q <= '0;
    end else if (start_scan) begin
      ray_x_q <= ray_x_in;
      ray_y_q <= ray_y_in;
      ray_z_q <= ray_z_in;
    end
  end

  // Memory data arrives one cycle after its address; pair it with the matching delayed issue flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      qvalid_q <= 1'b0;
      qblk_x_q <= '0;
      qblk_y_q <= '0;
      qblk_z_q <= '0;
    end else begin
      qvalid_q <= issue_d1_q;
      if (issue_d1_q) begin
        qblk_x_q <= block_pos_x_in;
        qblk_y_q <= block_pos_y_in;
        qblk_z_q <= block_pos_z_in;
      end
    end
  end

  nearest_hit_reducer #(
    .IDX_W (ADDR_W)
  ) u_reducer (
    .clk_i        (clk_in),
    .rst_n_i      (rst_n_in),
    .clear_i      (start_scan),
    .valid_i      (accept),
    .hit_i        (isect_hit_in),
    .t_i          (isect_t_in),
    .index_i      (ADDR_W'(ret_cnt_q)),
    .best_valid_o (rec_valid),
    .best_index_o (rec_index),
    .best_t_o     (rec_t)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_q       <= 1'b0;
      hit_index_q <= '0;
      hit_t_q     <= FLOAT_POS_INF;
    end else if (enter_done) begin
      hit_q       <= rec_valid;
      hit_index_q <= rec_index;
      hit_t_q     <= rec_t;
    end
  end

  assign busy_out          = (state_q != ST_IDLE);
  assign done_out          = (state_q == ST_DONE);
  assign block_addr_out    = addr_q;
  assign isect_ray_x_out   = ray_x_q;
  assign isect_ray_y_out   = ray_y_q;
  assign isect_ray_z_out   = ray_z_q;
  assign isect_block_x_out = qblk_x_q;
  assign isect_block_y_out = qblk_y_q;
  assign isect_block_z_out = qblk_z_q;
  assign isect_valid_out   = qvalid_q;
  assign hit_out           = hit_q;
  assign hit_index_out     = hit_index_q;
  assign hit_t_out         = hit_t_q;

endmodule

// File: tb/tb_ray_nearest_block_scan.sv
// Bench for ray_nearest_block_scan: block memory and 10-cycle intersection models,
// reference nearest-hit search over the programmed result table, directed and random scans.
module tb_ray_nearest_block_scan;
  import ray_pkg::*;

  localparam int NB  = 4;
  localparam int AW  = 2;
  localparam int LAT = 10;
  localparam logic [31:0] INF = 32'h7F80_0000;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          start_in;
  logic [31:0]   ray_x_in, ray_y_in, ray_z_in;
  logic          busy_out;
  logic [AW-1:0] block_addr_out;
  logic [31:0]   block_pos_x_in, block_pos_y_in, block_pos_z_in;
  logic [31:0]   isect_ray_x_out, isect_ray_y_out, isect_ray_z_out;
  logic [31:0]   isect_block_x_out, isect_block_y_out, isect_block_z_out;
  logic          isect_valid_out;
  logic          isect_hit_in;
  logic [31:0]   isect_t_in;
  logic          isect_valid_in;
  logic          hit_out;
  logic [AW-1:0] hit_index_out;
  logic [31:0]   hit_t_out;
  logic          done_out;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  ray_nearest_block_scan #(.NUM_BLOCKS(NB)) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .start_in          (start_in),
    .ray_x_in          (ray_x_in),
    .ray_y_in          (ray_y_in),
    .ray_z_in          (ray_z_in),
    .busy_out          (busy_out),
    .block_addr_out    (block_addr_out),
    .block_pos_x_in    (block_pos_x_in),
    .block_pos_y_in    (block_pos_y_in),
    .block_pos_z_in    (block_pos_z_in),
    .isect_ray_x_out   (isect_ray_x_out),
    .isect_ray_y_out   (isect_ray_y_out),
    .isect_ray_z_out   (isect_ray_z_out),
    .isect_block_x_out (isect_block_x_out),
    .isect_block_y_out (isect_block_y_out),
    .isect_block_z_out (isect_block_z_out),
    .isect_valid_out   (isect_valid_out),
    .isect_hit_in      (isect_hit_in),
    .isect_t_in        (isect_t_in),
    .isect_valid_in    (isect_valid_in),
    .hit_out           (hit_out),
    .hit_index_out     (hit_index_out),
    .hit_t_out         (hit_t_out),
    .done_out          (done_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Block memory: synchronous read, x position tagged with its index in the low bits.
  bit [31:0] mem_x [NB];
  bit [31:0] mem_y [NB];
  bit [31:0] mem_z [NB];

  always @(posedge clk_in) begin
    block_pos_x_in <= mem_x[block_addr_out];
    block_pos_y_in <= mem_y[block_addr_out];
    block_pos_z_in <= mem_z[block_addr_out];
  end

  // Intersection model: result per block index from a table, fixed latency, in order.
  bit        res_hit [NB];
  bit [31:0] res_t   [NB];
  bit        pv [LAT];
  bit        ph [LAT];
  bit [31:0] pt [LAT];

  always @(posedge clk_in) begin
    pv[0] <= isect_valid_out;
    ph[0] <= res_hit[isect_block_x_out[1:0]];
    pt[0] <= res_t[isect_block_x_out[1:0]];
    for (int k = 1; k < LAT; k++) begin
      pv[k] <= pv[k-1];
      ph[k] <= ph[k-1];
      pt[k] <= pt[k-1];
    end
  end

  assign isect_valid_in = pv[LAT-1];
  assign isect_hit_in   = ph[LAT-1];
  assign isect_t_in     = pt[LAT-1];

  // Reference: smallest non-negative finite t among hits, first index wins ties.
  task automatic ref_nearest(output logic eh, output logic [31:0] ei, output logic [31:0] et);
    eh = 1'b0;
    ei = 0;
    et = INF;
    for (int i = 0; i < NB; i++) begin
      logic [31:0] t;
      logic        usable;
      t = res_t[i];
      usable = res_hit[i] && (t[31] == 1'b0) && (t[30:23] != 8'hFF);
      if (usable && (!eh || t < et)) begin
        eh = 1'b1;
        ei = i;
        et = t;
      end
    end
  endtask

  task automatic clear_res();
    for (int i = 0; i < NB; i++) begin
      res_hit[i] = 1'b0;
      res_t[i]   = 32'h0;
    end
  endtask

  function automatic logic [31:0] rand_t();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       rand_t = {1'b1, 8'($urandom_range(0, 254)), 23'($urandom)};
      1:       rand_t = {1'b0, 8'hFF, 1'b1, 22'($urandom)};
      2:       rand_t = INF;
      3:       rand_t = 32'h3F80_0000;
      4:       rand_t = 32'h4000_0000;
      default: rand_t = {1'b0, 8'($urandom_range(0, 254)), 23'($urandom)};
    endcase
  endfunction

  task automatic run_scan(input bit mid_start, input bit rst_mid);
    logic [31:0] rx, ry, rz, tmp;
    logic        eh;
    logic [31:0] ei, et;
    int          first, nvalid, done_c, ndone;

    for (int i = 0; i < NB; i++) begin
      tmp = $urandom();
      mem_x[i] = {tmp[31:2], 2'(i)};
      mem_y[i] = $urandom();
      mem_z[i] = $urandom();
    end
    rx = $urandom(); ry = $urandom(); rz = $urandom();
    ref_nearest(eh, ei, et);

    @(negedge clk_in);
    ray_x_in = rx; ray_y_in = ry; ray_z_in = rz;
    start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    ray_x_in = $urandom(); ray_y_in = $urandom(); ray_z_in = $urandom();
    chk("busy_at_start", 32'(busy_out), 1);
    chk("addr_at_start", 32'(block_addr_out), 0);

    first = -1; nvalid = 0; done_c = -1; ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      if (mid_start && c == 5) start_in = 1'b1;
      if (mid_start && c == 6) start_in = 1'b0;
      if (rst_mid && c == 8) begin
        rst_n_in = 1'b0;
        #1;
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_done", 32'(done_out), 0);
        chk("rst_hit", 32'(hit_out), 0);
        chk("rst_hit_t", hit_t_out, INF);
        chk("rst_qvalid", 32'(isect_valid_out), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int s = 0; s < 15; s++) begin
          @(posedge clk_in);
          #1;
          chk("stale_busy", 32'(busy_out), 0);
          chk("stale_done", 32'(done_out), 0);
        end
        chk("stale_hit", 32'(hit_out), 0);
        chk("stale_hit_t", hit_t_out, INF);
        return;
      end
      @(posedge clk_in);
      #1;
      if (c <= NB - 1) chk("addr_seq", 32'(block_addr_out), c);
      if (isect_valid_out) begin
        if (first < 0) first = c;
        chk("valid_contig", c, first + nvalid);
        if (nvalid < NB) begin
          chk("q_blk_x", isect_block_x_out, mem_x[nvalid]);
          chk("q_blk_y", isect_block_y_out, mem_y[nvalid]);
          chk("q_blk_z", isect_block_z_out, mem_z[nvalid]);
        end
        chk("q_ray_x", isect_ray_x_out, rx);
        chk("q_ray_y", isect_ray_y_out, ry);
        chk("q_ray_z", isect_ray_z_out, rz);
        nvalid++;
      end
      if (done_c < 0) chk("busy_hold", 32'(busy_out), 1);
      if (done_out) begin
        ndone++;
        if (done_c < 0) begin
          done_c = c;
          chk("hit", 32'(hit_out), 32'(eh));
          chk("hit_index", 32'(hit_index_out), ei);
          chk("hit_t", hit_t_out, et);
        end
      end else if (done_c >= 0 && c == done_c + 1) begin
        chk("busy_fall", 32'(busy_out), 0);
        break;
      end
    end
    chk("valid_first", first, 2);
    chk("valid_count", nvalid, NB);
    chk("done_cycle", done_c, NB + LAT + 2);
    chk("done_pulses", ndone, 1);
  endtask

  initial begin
    rst_n_in = 1'b0;
    start_in = 1'b0;
    ray_x_in = '0; ray_y_in = '0; ray_z_in = '0;
    clear_res();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("reset_busy", 32'(busy_out), 0);
    chk("reset_done", 32'(done_out), 0);
    chk("reset_hit", 32'(hit_out), 0);
    chk("reset_index", 32'(hit_index_out), 0);
    chk("reset_hit_t", hit_t_out, INF);
    chk("reset_qvalid", 32'(isect_valid_out), 0);
    chk("reset_addr", 32'(block_addr_out), 0);

    clear_res();
    res_hit[2] = 1'b1; res_t[2] = 32'h4040_0000;
    run_scan(1'b1, 1'b0);

    clear_res();
    res_hit[1] = 1'b1; res_t[1] = 32'h40A0_0000;
    res_hit[3] = 1'b1; res_t[3] = 32'h4000_0000;
    run_scan(1'b0, 1'b0);

    clear_res();
    res_hit[0] = 1'b1; res_t[0] = 32'h3F80_0000;
    res_hit[2] = 1'b1; res_t[2] = 32'h3F80_0000;
    run_scan(1'b0, 1'b0);

    clear_res();
    run_scan(1'b0, 1'b0);

    clear_res();
    res_hit[1] = 1'b1; res_t[1] = 32'hBF80_0000;
    res_hit[2] = 1'b1; res_t[2] = 32'h7FC0_0000;
    res_hit[3] = 1'b1; res_t[3] = INF;
    res_t[0] = 32'h3F80_0000;
    run_scan(1'b0, 1'b0);

    clear_res();
    res_hit[1] = 1'b1; res_t[1] = 32'h3F00_0000;
    run_scan(1'b0, 1'b1);
    clear_res();
    res_hit[3] = 1'b1; res_t[3] = 32'h4120_0000;
    run_scan(1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NB; i++) begin
        res_hit[i] = ($urandom_range(0, 3) != 0);
        res_t[i]   = rand_t();
      end
      run_scan(n[0], 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
